// File: rtl/seq_muldiv.sv
// Iterative 16-bit multiply/divide: shift-add multiply, restoring divide, one bit per clock.
// Optional two's-complement mode is enabled by defining MULDIV_SIGNED_EN (adds the Signed port).
module seq_muldiv #(
   parameter int WIDTH = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
`ifdef MULDIV_SIGNED_EN
   input  logic             Signed,
`endif
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ResultLo,
   output logic [WIDTH-1:0] ResultHi,
   output logic             DivZero
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

   state_t             state_reg;
   logic [4:0]         cnt_reg;
   logic               op_reg;
   logic               neg_lo_reg;
   logic               neg_hi_reg;
   logic [WIDTH-1:0]   mcand_reg;
   logic [WIDTH-1:0]   hi_reg;
   logic [WIDTH-1:0]   lo_reg;
   logic               busy_reg;
   logic               done_reg;
   logic [WIDTH-1:0]   res_lo_reg;
   logic [WIDTH-1:0]   res_hi_reg;
   logic               divzero_reg;

   logic               signed_sel;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_sub;
   logic               div_ok;
   logic [WIDTH-1:0]   hi_next;
   logic [WIDTH-1:0]   lo_next;
   logic [2*WIDTH-1:0] prod_mag;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   res_lo_next;
   logic [WIDTH-1:0]   res_hi_next;

`ifdef MULDIV_SIGNED_EN
   assign signed_sel = Signed;
`else
   assign signed_sel = 1'b0;
`endif

   // Iterate on magnitudes; the sign is reapplied when the result is written.
   assign a_neg = signed_sel & A[WIDTH-1];
   assign b_neg = signed_sel & B[WIDTH-1];
   assign a_mag = a_neg ? (~A + 1'b1) : A;
   assign b_mag = b_neg ? (~B + 1'b1) : B;

   always_comb begin
      mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : '0);
      div_shift = {hi_reg, lo_reg[WIDTH-1]};
      div_ok    = (div_shift >= {1'b0, mcand_reg});
      // Only the low bits of the difference matter: when div_ok holds it is below the divisor.
      div_sub   = div_shift[WIDTH-1:0] - mcand_reg;
      if (op_reg) begin
         hi_next = div_ok ? div_sub : div_shift[WIDTH-1:0];
         lo_next = {lo_reg[WIDTH-2:0], div_ok};
      end else begin
         hi_next = mul_sum[WIDTH:1];
         lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
      end

      prod_mag = {hi_next, lo_next};
      prod_fix = neg_lo_reg ? (~prod_mag + 1'b1) : prod_mag;
      if (op_reg) begin
         res_lo_next = neg_lo_reg ? (~lo_next + 1'b1) : lo_next;
         res_hi_next = neg_hi_reg ? (~hi_next + 1'b1) : hi_next;
      end else begin
         res_lo_next = prod_fix[WIDTH-1:0];
         res_hi_next = prod_fix[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         op_reg      <= 1'b0;
         neg_lo_reg  <= 1'b0;
         neg_hi_reg  <= 1'b0;
         mcand_reg   <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         res_lo_reg  <= '0;
         res_hi_reg  <= '0;
         divzero_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (Start) begin
                  op_reg      <= Op;
                  cnt_reg     <= '0;
                  divzero_reg <= 1'b0;
                  hi_reg      <= '0;
                  if (Op) begin
                     mcand_reg  <= b_mag;
                     lo_reg     <= a_mag;
                     neg_lo_reg <= a_neg ^ b_neg;
                     neg_hi_reg <= a_neg;
                  end else begin
                     mcand_reg  <= a_mag;
                     lo_reg     <= b_mag;
                     neg_lo_reg <= a_neg ^ b_neg;
                     neg_hi_reg <= a_neg ^ b_neg;
                  end
                  if (Op && (B == '0)) begin
                     // No iterations; DONE raises the pulse on its first cycle.
                     state_reg   <= DONE;
                     res_lo_reg  <= '1;
                     res_hi_reg  <= A;
                     divzero_reg <= 1'b1;
                  end else begin
                     state_reg <= RUN;
                     busy_reg  <= 1'b1;
                  end
               end
            end
            RUN: begin
               cnt_reg <= cnt_reg + 5'd1;
               hi_reg  <= hi_next;
               lo_reg  <= lo_next;
               if (cnt_reg == CNT_LAST) begin
                  state_reg  <= DONE;
                  busy_reg   <= 1'b0;
                  done_reg   <= 1'b1;
                  res_lo_reg <= res_lo_next;
                  res_hi_reg <= res_hi_next;
               end
            end
            DONE: begin
               if (done_reg) begin
                  done_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  done_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign Busy     = busy_reg;
   assign Done     = done_reg;
   assign ResultLo = res_lo_reg;
   assign ResultHi = res_hi_reg;
   assign DivZero  = divzero_reg;

endmodule

// File: tb/tb_seq_muldiv.sv
// Scoreboard bench for seq_muldiv: driver pushes model results, a monitor pops them on Done.
// Signed-mode tests are included when MULDIV_SIGNED_EN is defined.
module tb_seq_muldiv;

`ifdef MULDIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Start;
   logic        Op;
   logic [15:0] A;
   logic [15:0] B;
   logic        Signed;
   logic        Busy;
   logic        Done;
   logic [15:0] ResultLo;
   logic [15:0] ResultHi;
   logic        DivZero;

   typedef struct {
      logic        op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] lo;
      logic [15:0] hi;
      logic        dz;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   seq_muldiv dut (
      .Clock(Clock),
      .Reset(Reset),
      .Start(Start),
      .Op(Op),
      .A(A),
      .B(B),
`ifdef MULDIV_SIGNED_EN
      .Signed(Signed),
`endif
      .Busy(Busy),
      .Done(Done),
      .ResultLo(ResultLo),
      .ResultHi(ResultHi),
      .DivZero(DivZero)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference: plain integer arithmetic on sign- or zero-extended operands.
   function automatic exp_t model(input logic op, input logic [15:0] a, input logic [15:0] b,
                                  input logic sgn);
      exp_t   e;
      longint sa;
      longint sb;
      longint q;
      longint r;
      e.op = op;
      e.a  = a;
      e.b  = b;
      e.dz = 1'b0;
      if (SIGNED_EN && sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'(a);
         sb = longint'(b);
      end
      if (!op) begin
         r    = sa * sb;
         e.lo = r[15:0];
         e.hi = r[31:16];
      end else if (b == 16'h0000) begin
         e.lo = 16'hFFFF;
         e.hi = a;
         e.dz = 1'b1;
      end else begin
         q    = sa / sb;
         r    = sa % sb;
         e.lo = q[15:0];
         e.hi = r[15:0];
      end
      return e;
   endfunction

   // Monitor: every Done pulse must match the oldest outstanding expectation.
   always @(negedge Clock) begin
      if (Done === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got Done=1, expected no pending operation");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("result_lo", {16'h0, ResultLo}, {16'h0, e.lo});
            check("result_hi", {16'h0, ResultHi}, {16'h0, e.hi});
            check("div_zero", {31'h0, DivZero}, {31'h0, e.dz});
            $display("[TB] op=%0d a=%h b=%h -> hi=%h lo=%h dz=%b", e.op, e.a, e.b,
                     ResultHi, ResultLo, DivZero);
         end
      end
   end

   task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                         input logic sgn);
      int   cyc;
      int   busy_cnt;
      logic dz;
      @(negedge Clock);
      Op     = op;
      A      = a;
      B      = b;
      Signed = sgn;
      Start  = 1'b1;
      exp_q.push_back(model(op, a, b, sgn));
      dz       = op && (b == 16'h0000);
      cyc      = 0;
      busy_cnt = 0;
      do begin
         @(negedge Clock);
         cyc++;
         if (cyc == 1) begin
            // Operands must already be captured; scramble the bus.
            Start  = 1'b0;
            A      = 16'($urandom);
            B      = 16'($urandom);
            Op     = 1'($urandom);
            Signed = 1'($urandom);
         end
         if (Busy === 1'b1) busy_cnt++;
      end while (Done !== 1'b1 && cyc < 40);
      check("latency", cyc, dz ? 2 : 17);
      check("busy_cycles", busy_cnt, dz ? 0 : 16);
      @(negedge Clock);
      check("done_pulse_width", {31'h0, Done}, 32'h0);
   endtask

   task automatic check_res(input string name, input logic [15:0] hi, input logic [15:0] lo,
                            input logic dz);
      check(name, {ResultHi, ResultLo}, {hi, lo});
      check({name, "_dz"}, {31'h0, DivZero}, {31'h0, dz});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int n_done;
      Reset  = 1'b1;
      Start  = 1'b0;
      Op     = 1'b0;
      A      = '0;
      B      = '0;
      Signed = 1'b0;
      repeat (3) @(negedge Clock);
      Reset = 1'b0;
      check("reset_busy", {31'h0, Busy}, 32'h0);
      check("reset_done", {31'h0, Done}, 32'h0);
      check_res("reset_results", 16'h0000, 16'h0000, 1'b0);

      run_op(1'b0, 16'h1234, 16'h0010, 1'b0);
      check_res("mul_1234x0010", 16'h0001, 16'h2340, 1'b0);
      run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
      check_res("mul_ffffxffff", 16'hFFFE, 16'h0001, 1'b0);

      // 100/7 with Start held through RUN and DONE.
      @(negedge Clock);
      Op    = 1'b1;
      A     = 16'd100;
      B     = 16'd7;
      Start = 1'b1;
      exp_q.push_back(model(1'b1, 16'd100, 16'd7, 1'b0));
      cyc = 0;
      do begin
         @(negedge Clock);
         cyc++;
      end while (Done !== 1'b1 && cyc < 40);
      check("hold_latency", cyc, 17);
      check_res("div_100_7", 16'h0002, 16'h000E, 1'b0);
      exp_q.push_back(model(1'b1, 16'd100, 16'd7, 1'b0));
      @(negedge Clock);
      check("hold_idle_busy", {31'h0, Busy}, 32'h0);
      @(negedge Clock);
      check("hold_reaccept_busy", {31'h0, Busy}, 32'h1);
      Start = 1'b0;
      A     = 16'hBEEF;
      B     = 16'h0000;
      cyc   = 0;
      do begin
         @(negedge Clock);
         cyc++;
      end while (Done !== 1'b1 && cyc < 40);
      check("hold_second_latency", cyc, 16);
      @(negedge Clock);

      run_op(1'b1, 16'h1234, 16'h0000, 1'b0);
      check_res("div_by_zero", 16'h1234, 16'hFFFF, 1'b1);
      run_op(1'b1, 16'd50, 16'd5, 1'b0);
      check_res("div_after_zero", 16'h0000, 16'h000A, 1'b0);

      // Reset at iteration 8 aborts without a Done pulse.
      @(negedge Clock);
      Op    = 1'b0;
      A     = 16'h1234;
      B     = 16'h5678;
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      repeat (7) @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      check("abort_busy", {31'h0, Busy}, 32'h0);
      check_res("abort_results", 16'h0000, 16'h0000, 1'b0);
      n_done = 0;
      repeat (25) begin
         @(negedge Clock);
         if (Done === 1'b1) n_done++;
      end
      check("abort_no_done", n_done, 0);

      // Reset and Start together: Start is not accepted.
      Reset = 1'b1;
      Start = 1'b1;
      Op    = 1'b0;
      @(negedge Clock);
      Reset = 1'b0;
      Start = 1'b0;
      check("reset_start_busy", {31'h0, Busy}, 32'h0);
      @(negedge Clock);
      check("reset_start_idle", {30'h0, Busy, Done}, 32'h0);

`ifdef MULDIV_SIGNED_EN
      run_op(1'b0, 16'hFFF9, 16'h0003, 1'b1);
      check_res("smul_m7x3", 16'hFFFF, 16'hFFEB, 1'b0);
      run_op(1'b1, 16'hFFF9, 16'h0002, 1'b1);
      check_res("sdiv_m7d2", 16'hFFFF, 16'hFFFD, 1'b0);
      run_op(1'b1, 16'h8000, 16'hFFFF, 1'b1);
      check_res("sdiv_8000dffff", 16'h0000, 16'h8000, 1'b0);
`endif

      for (int i = 0; i < 40; i++) begin
         logic        r_op;
         logic [15:0] r_a;
         logic [15:0] r_b;
         r_op = 1'($urandom_range(0, 1));
         r_a  = 16'($urandom);
         r_b  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         run_op(r_op, r_a, r_b, 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge Clock);
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
